// File: rtl/piso_reader.sv
// Reads one frame from an external parallel-in/serial-out register: load strobe, then WIDTH shift-clock pulses, MSB first.
// Optional macro PISO_READER_CHANGE_DETECT_EN adds o_changed, flagging frames whose value differs from the previous one.
module piso_reader #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic             i_serial_data,
  output logic             o_load_n,
  output logic             o_sclk,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy
`ifdef PISO_READER_CHANGE_DETECT_EN
  ,
  output logic             o_changed
`endif
);

  localparam int PW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q;
  logic              load_n_q, sclk_q, valid_q, busy_q;
  logic              phase_last;

  assign phase_last = (phase_q == PH_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD;
          phase_d = '0;
        end
      end
      LOAD: begin
        if (phase_last) begin
          state_d = SHIFT_LO;
          phase_d = '0;
          bit_d   = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_LO: begin
        // Sample just before o_sclk rises, while the external bit is settled.
        if (phase_last) begin
          shift_d = {shift_q[WIDTH-2:0], i_serial_data};
          state_d = SHIFT_HI;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      SHIFT_HI: begin
        if (phase_last) begin
          phase_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = SHIFT_LO;
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align with the state they belong to.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      load_n_q <= 1'b1;
      sclk_q   <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      load_n_q <= (state_d != LOAD);
      sclk_q   <= (state_d == SHIFT_HI);
      busy_q   <= (state_d != IDLE);
      valid_q  <= (state_q == DONE);
      if (state_q == DONE) data_q <= shift_q;
    end
  end

`ifdef PISO_READER_CHANGE_DETECT_EN
  logic changed_q;
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) changed_q <= 1'b0;
    else            changed_q <= (state_q == DONE) && (shift_q != data_q);
  end
  assign o_changed = changed_q;
`endif

  assign o_load_n = load_n_q;
  assign o_sclk   = sclk_q;
  assign o_data   = data_q;
  assign o_valid  = valid_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_piso_reader.sv
// Scoreboard bench for piso_reader: a default instance (8 bits, 4 clocks/bit) and a narrow fast one (4 bits, 1 clock/bit),
// each reading from a behavioural PISO register model.
module tb_piso_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          due;
    logic        chg;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic rst_n = 1'b0;

  // ---- instance A: defaults ----
  logic       a_start = 1'b0, a_ser, a_load_n, a_sclk, a_valid, a_busy;
  logic [7:0] a_data, a_pat = 8'h00, a_sr = 8'h00, prev_a = 8'h00;
  logic       a_sclk_d = 1'b0;
`ifdef PISO_READER_CHANGE_DETECT_EN
  logic       a_changed;
`endif

  piso_reader dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(a_start), .i_serial_data(a_ser),
    .o_load_n(a_load_n), .o_sclk(a_sclk), .o_data(a_data), .o_valid(a_valid), .o_busy(a_busy)
`ifdef PISO_READER_CHANGE_DETECT_EN
    , .o_changed(a_changed)
`endif
  );

  // ---- instance B: 4 bits, 1 clock per half-bit ----
  logic       b_start = 1'b0, b_ser, b_load_n, b_sclk, b_valid, b_busy;
  logic [3:0] b_data, b_pat = 4'h0, b_sr = 4'h0;
  logic       b_sclk_d = 1'b0;
`ifdef PISO_READER_CHANGE_DETECT_EN
  logic       b_changed;
`endif

  piso_reader #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(b_start), .i_serial_data(b_ser),
    .o_load_n(b_load_n), .o_sclk(b_sclk), .o_data(b_data), .o_valid(b_valid), .o_busy(b_busy)
`ifdef PISO_READER_CHANGE_DETECT_EN
    , .o_changed(b_changed)
`endif
  );

  // External shift registers: parallel load while load_n low, shift on sclk rising edge.
  always @(posedge clk) begin
    if (!a_load_n) a_sr <= a_pat;
    else if (a_sclk && !a_sclk_d) a_sr <= {a_sr[6:0], 1'b0};
    a_sclk_d <= a_sclk;
    if (!b_load_n) b_sr <= b_pat;
    else if (b_sclk && !b_sclk_d) b_sr <= {b_sr[2:0], 1'b0};
    b_sclk_d <= b_sclk;
  end
  assign a_ser = a_sr[7];
  assign b_ser = b_sr[3];

  // Monitors: count strobes per frame and check each o_valid against the scoreboard.
  int   la_cnt = 0, sa_cnt = 0, lb_cnt = 0, sb_cnt = 0;
  logic a_load_p = 1'b1, a_sclk_p = 1'b0, b_load_p = 1'b1, b_sclk_p = 1'b0;
  exp_t ea, eb;

  always @(negedge clk) begin
    if (!a_load_n && a_load_p) begin la_cnt = 1; sa_cnt = 0; end
    else if (!a_load_n) la_cnt++;
    if (a_sclk && !a_sclk_p) sa_cnt++;
    if (a_valid) begin
      if (qa.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
      else begin
        ea = qa.pop_front();
        check("a_data", 32'(a_data), ea.data);
        check("a_latency", cyc, ea.due);
        check("a_load_cycles", la_cnt, 4);
        check("a_sclk_pulses", sa_cnt, 8);
        $display("A frame data=%02h at cycle %0d", a_data, cyc);
`ifdef PISO_READER_CHANGE_DETECT_EN
        check("a_changed", 32'(a_changed), 32'(ea.chg));
`endif
      end
    end
    a_load_p = a_load_n;
    a_sclk_p = a_sclk;

    if (!b_load_n && b_load_p) begin lb_cnt = 1; sb_cnt = 0; end
    else if (!b_load_n) lb_cnt++;
    if (b_sclk && !b_sclk_p) sb_cnt++;
    if (b_valid) begin
      if (qb.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
      else begin
        eb = qb.pop_front();
        check("b_data", 32'(b_data), eb.data);
        check("b_latency", cyc, eb.due);
        check("b_load_cycles", lb_cnt, 1);
        check("b_sclk_pulses", sb_cnt, 4);
        $display("B frame data=%01h at cycle %0d", b_data, cyc);
      end
    end
    b_load_p = b_load_n;
    b_sclk_p = b_sclk;
  end

  // Start edge is the posedge after the driving negedge; valid shows one latency later.
  task automatic push_a(input logic [7:0] pat, input int start_edge);
    exp_t e;
    e.data = 32'(pat);
    e.due  = start_edge + 69;
    e.chg  = (pat != prev_a);
    prev_a = pat;
    qa.push_back(e);
  endtask

  task automatic wait_a_drain();
    for (int i = 0; i < 400 && qa.size() != 0; i++) @(negedge clk);
    check("a_drain", qa.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_b_drain();
    for (int i = 0; i < 100 && qb.size() != 0; i++) @(negedge clk);
    check("b_drain", qb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_a(input logic [7:0] pat);
    a_pat = pat;
    push_a(pat, cyc + 1);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_a_drain();
  endtask

  task automatic frame_b(input logic [3:0] pat);
    exp_t e;
    b_pat  = pat;
    e.data = 32'(pat);
    e.due  = cyc + 1 + 10;
    e.chg  = 1'b0;
    qb.push_back(e);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_b_drain();
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_load_n", 32'(a_load_n), 32'd1);
    check("rst_sclk",   32'(a_sclk),   32'd0);
    check("rst_data",   32'(a_data),   32'd0);
    check("rst_valid",  32'(a_valid),  32'd0);
    check("rst_busy",   32'(a_busy),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame.
    frame_a(8'hA5);

    // Extra starts during a busy frame are dropped.
    a_pat = 8'h5A;
    n = cyc;
    push_a(8'h5A, n + 1);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (9) @(negedge clk);
    check("a_busy_mid", 32'(a_busy), 32'd1);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (29) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_a_drain();
    check("a_hold_data", 32'(a_data), 32'h5A);

    // Reset mid-frame aborts without o_valid and clears o_data.
    a_pat = 8'hFF;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy",   32'(a_busy),   32'd0);
    check("abort_data",   32'(a_data),   32'd0);
    check("abort_load_n", 32'(a_load_n), 32'd1);
    check("abort_sclk",   32'(a_sclk),   32'd0);
    prev_a = 8'h00;
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("abort_data_held", 32'(a_data), 32'd0);

    // Change detection sequence; first frame compares against the reset value.
    frame_a(8'h12);
    frame_a(8'h12);
    frame_a(8'h34);

    // Start held high: back-to-back frames 70 cycles apart.
    a_pat = 8'h3C;
    n = cyc;
    push_a(8'h3C, n + 1);
    push_a(8'hC3, n + 71);
    a_start = 1'b1;
    repeat (10) @(negedge clk);
    a_pat = 8'hC3;
    repeat (130) @(negedge clk);
    a_start = 1'b0;
    wait_a_drain();

    // Boundary patterns.
    frame_a(8'h00);
    frame_a(8'hFF);

    // Narrow, fastest configuration.
    frame_b(4'h9);
    frame_b(4'h6);

    repeat (20) @(negedge clk);
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_reader.md
PISO_READER -- requirements
Module: piso_reader

Interface
REQ-001 Parameter WIDTH, default 8, number of bits read per frame (legal range 2..32).
REQ-002 Parameter CLKS_PER_BIT, default 4, i_clock cycles per half-period of o_sclk and per load pulse (legal range 1..65535).
REQ-003 i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  synchronous, active-low reset.
REQ-005 i_start  input  1  request one frame read; sampled only in IDLE.
REQ-006 i_serial_data  input  1  serial data from external parallel-in/serial-out register, MSB first.
REQ-007 o_load_n  output  1  active-low parallel-load strobe to external register.
REQ-008 o_sclk  output  1  shift clock to external register; idle low.
REQ-009 o_data  output  WIDTH  last completed frame, MSB = first bit received.
REQ-010 o_valid  output  1  one-cycle pulse when o_data updates.
REQ-011 o_busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
REQ-013 IDLE: o_load_n=1, o_sclk=0; i_start=1 at an edge -> LOAD next cycle.
REQ-014 LOAD: o_load_n=0 for exactly CLKS_PER_BIT cycles, then SHIFT_LO with bit counter = 0.
REQ-015 SHIFT_LO: o_sclk=0 for CLKS_PER_BIT cycles; on its last cycle sample i_serial_data into shift register LSB, shifting left.
REQ-016 SHIFT_HI: o_sclk=1 for CLKS_PER_BIT cycles; then increment bit counter; counter = WIDTH-1 -> DONE, else SHIFT_LO.
REQ-017 DONE: single cycle; o_data <= shift register, o_valid=1, then IDLE.
REQ-018 Latency: o_valid high exactly CLKS_PER_BIT*(1+2*WIDTH)+1 cycles after the edge that sampled i_start (69 cycles at defaults).
REQ-019 i_start asserted while o_busy=1 SHALL be ignored, not queued.
REQ-020 i_start held high continuously SHALL produce back-to-back frames, one IDLE cycle between DONE and the next LOAD.
REQ-021 o_data SHALL hold its value between frames; only DONE changes it.
REQ-022 Phase counter width SHALL be clog2(CLKS_PER_BIT)+1; bit counter width clog2(WIDTH)+1; no wrap before terminal count.
REQ-023 o_load_n, o_sclk, o_valid, o_busy SHALL be registered outputs, glitch-free.

Reset
REQ-024 i_reset_n=0 at an edge SHALL force IDLE, o_load_n=1, o_sclk=0, o_data=0, o_valid=0, o_busy=0, counters and shift register 0.
REQ-025 Reset mid-frame SHALL abort the frame with no o_valid pulse and o_data cleared to 0.
REQ-026 Reset has priority over i_start in the same cycle.

Configuration
REQ-027 Macro PISO_READER_CHANGE_DETECT_EN SHALL add output o_changed (1 bit).
REQ-028 With macro defined: o_changed pulses with o_valid only when new o_data differs from previous o_data; first frame after reset compares against 0; reset value 0.
REQ-029 Without macro: port o_changed and its comparison logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 Defaults, external pattern 0xA5, single i_start pulse -> o_load_n low 4 cycles, 8 o_sclk pulses, o_data=0xA5, o_valid at cycle 69.
REQ-031 Extra i_start pulses at cycles 10 and 40 of a frame -> ignored; exactly one o_valid.
REQ-032 i_reset_n low at cycle 30 of a frame reading 0xFF -> IDLE next cycle, o_data=0x00, no o_valid.
REQ-033 i_start held high, patterns 0x3C then 0xC3 -> two o_valid pulses 70 cycles apart, o_data 0x3C then 0xC3.
REQ-034 WIDTH=4, CLKS_PER_BIT=1, pattern 0x9 -> o_data=0x9, o_valid 10 cycles after start.
REQ-035 Macro defined, frames 0x12, 0x12, 0x34 -> o_changed pulses on frames 1 and 3 only.
